cache_way_array: RTL

Parametrised, multi-way storage array for the cache datapath. It holds data and a valid bit for each (set, way), and reads all ways of one set in parallel. Reads are synchronous (registered) with same-cycle write-forwarding. Writes use byte-masks. Clearing is sequential, one set per cycle, triggered by reset or flush. It replaces the fixed 8-entry single-way arrays in the instruction and data caches.

---
 rtl/cache_way_array.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/cache_way_array.sv
// rtl/cache_way_array.sv - multi-way cache storage array with sweep clear and write forwarding
//
// Purpose: SETS x WAYS array of WIDTH-bit entries plus a valid bit per entry.
// All ways of one set are read in parallel with a registered (1-cycle) read.
// Writes are byte-masked; a read of the set being written in the same cycle
// returns the merged data. Reset or flush clears the array one set per cycle.
// Optional macro ARRAY_PARITY_EN adds one even-parity bit per entry.
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset; starts a clear sweep
//   flush      one-cycle pulse; starts a clear sweep when idle
//   busy       high while a clear sweep is running
//   read       read request, rindex selects the set
//   load       write request, windex/wway/wmask/datain
//   dataout    registered read data, way w at [w*WIDTH +: WIDTH]
//   valid_out  registered valid bit per way
//   rvalid     dataout/valid_out updated by a read this cycle
//   parity_err registered parity error per way (0 unless ARRAY_PARITY_EN)

module cache_way_array #(
  parameter int WIDTH   = 32,
  parameter int S_INDEX = 3,
  parameter int WAYS    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  output logic                    busy,
  input  logic                    read,
  input  logic [S_INDEX-1:0]      rindex,
  input  logic                    load,
  input  logic [S_INDEX-1:0]      windex,
  input  logic [WAYS-1:0]         wway,
  input  logic [WIDTH/8-1:0]      wmask,
  input  logic [WIDTH-1:0]        datain,
  output logic [WAYS*WIDTH-1:0]   dataout,
  output logic [WAYS-1:0]         valid_out,
  output logic                    rvalid,
  output logic [WAYS-1:0]         parity_err
);

  localparam int SETS = 1 << S_INDEX;
  localparam int NB   = WIDTH / 8;
  localparam logic [S_INDEX-1:0] LAST_SET = S_INDEX'(SETS - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t             state, state_nx;
  logic [S_INDEX-1:0] cnt, cnt_nx;

  logic [WIDTH-1:0] mem [SETS][WAYS];
  logic [WAYS-1:0]  vld [SETS];
`ifdef ARRAY_PARITY_EN
  logic [WAYS-1:0]  par [SETS];
  logic [WAYS-1:0]  perr_q;
`endif

  logic [WIDTH-1:0] merged [WAYS];
  logic             wr_en;
  logic             rd_en;
  logic             same_idx;

  // A flush arriving in the same cycle as a request wins: the request is dropped.
  assign wr_en    = load && (state == IDLE) && !flush && !rst;
  assign rd_en    = read && (state == IDLE) && !flush;
  assign same_idx = (rindex == windex);
  assign busy     = (state == CLEAR);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (flush) begin
          state_nx = CLEAR;
          cnt_nx   = '0;
        end
      end
      CLEAR: begin
        cnt_nx = cnt + 1'b1;
        if (cnt == LAST_SET) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Byte-merge of the currently stored entry with datain, per way.
  always_comb begin
    for (int w = 0; w < WAYS; w++) begin
      merged[w] = mem[windex][w];
      for (int b = 0; b < NB; b++) begin
        if (wmask[b]) merged[w][b*8 +: 8] = datain[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      for (int w = 0; w < WAYS; w++) begin
        mem[cnt][w] <= '0;
`ifdef ARRAY_PARITY_EN
        par[cnt][w] <= 1'b0;
`endif
      end
      vld[cnt] <= '0;
    end else if (wr_en) begin
      for (int w = 0; w < WAYS; w++) begin
        if (wway[w]) begin
          mem[windex][w] <= merged[w];
          vld[windex][w] <= 1'b1;
`ifdef ARRAY_PARITY_EN
          par[windex][w] <= ^merged[w];
`endif
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dataout   <= '0;
      valid_out <= '0;
      rvalid    <= 1'b0;
`ifdef ARRAY_PARITY_EN
      perr_q    <= '0;
`endif
    end else begin
      rvalid <= rd_en;
      if (rd_en) begin
        for (int w = 0; w < WAYS; w++) begin
          // Forwarded ways see the merged write; parity is fresh so no error.
          if (wr_en && same_idx && wway[w]) begin
            dataout[w*WIDTH +: WIDTH] <= merged[w];
            valid_out[w]              <= 1'b1;
`ifdef ARRAY_PARITY_EN
            perr_q[w]                 <= 1'b0;
`endif
          end else begin
            dataout[w*WIDTH +: WIDTH] <= mem[rindex][w];
            valid_out[w]              <= vld[rindex][w];
`ifdef ARRAY_PARITY_EN
            perr_q[w]                 <= vld[rindex][w] && (par[rindex][w] != ^mem[rindex][w]);
`endif
          end
        end
      end
    end
  end

`ifdef ARRAY_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = '0;
`endif

endmodule
